// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - multi-channel button synchroniser, debouncer and long-press/auto-repeat generator
//
// Purpose: per channel, synchronise a raw pin, accept a new level only after it
// has disagreed with the current level for NOISE_PERIOD consecutive cycles, and
// derive press/release pulses, a long-press level and auto-repeat pulses.
//
// Ports:
//   clk   in   1           system clock
//   rst   in   1           synchronous, active-high reset
//   din   in   DATA_WIDTH  raw asynchronous inputs
//   dout  out  DATA_WIDTH  debounced level (1 = pressed)
//   rise  out  DATA_WIDTH  one-cycle pulse in the first cycle of dout=1
//   fall  out  DATA_WIDTH  one-cycle pulse in the first cycle of dout=0
//   held  out  DATA_WIDTH  long press in progress
//   rpt   out  DATA_WIDTH  one-cycle pulse at long-press start and each repeat
module button_conditioner #(
  parameter int DATA_WIDTH    = 1,
  parameter int SYNC_STAGES   = 2,
  parameter int NOISE_PERIOD  = 256,
  parameter int HOLD_PERIOD   = 1024,
  parameter int REPEAT_PERIOD = 256,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [DATA_WIDTH-1:0] rise,
  output logic [DATA_WIDTH-1:0] fall,
  output logic [DATA_WIDTH-1:0] held,
  output logic [DATA_WIDTH-1:0] rpt
);

  // Noise counter only ever holds 0..NOISE_PERIOD-1; hold and repeat counters
  // must be able to hold their terminal value.
  localparam int NW = (NOISE_PERIOD < 2) ? 1 : $clog2(NOISE_PERIOD);
  localparam int HW = (HOLD_PERIOD < 2) ? 1 : $clog2(HOLD_PERIOD + 1);
  localparam int RW = (REPEAT_PERIOD < 2) ? 1 : $clog2(REPEAT_PERIOD + 1);

  localparam logic          INV        = (ACTIVE_LOW != 0);
  localparam logic [NW-1:0] NOISE_LAST = NW'(NOISE_PERIOD - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_PERIOD);
  localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_PERIOD);
  localparam logic          RPT_ON     = (REPEAT_PERIOD != 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRESS = 2'd1;
  localparam logic [1:0] ST_HELD  = 2'd2;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [NW-1:0]          noise_cnt;
    logic [HW-1:0]          hold_cnt;
    logic [RW-1:0]          rep_cnt;
    logic [1:0]             state_q;
    logic                   lvl_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   held_q;
    logic                   rpt_q;
    logic                   s;
    logic                   accept;
    logic                   going_up;
    logic                   going_down;

    assign s = sync_q[SYNC_STAGES-1];

    // The new level is taken on the edge where the disagreement count would
    // reach NOISE_PERIOD, so the counter never has to represent that value.
    assign accept     = (s != lvl_q) && (noise_cnt == NOISE_LAST);
    assign going_up   = accept && s;
    assign going_down = accept && !s;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q    <= '0;
        noise_cnt <= '0;
        hold_cnt  <= '0;
        rep_cnt   <= '0;
        state_q   <= ST_IDLE;
        lvl_q     <= 1'b0;
        rise_q    <= 1'b0;
        fall_q    <= 1'b0;
        held_q    <= 1'b0;
        rpt_q     <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], din[i] ^ INV};

        if (s == lvl_q) begin
          noise_cnt <= '0;
        end else if (accept) begin
          noise_cnt <= '0;
          lvl_q     <= s;
        end else begin
          noise_cnt <= noise_cnt + NW'(1);
        end

        rise_q <= going_up;
        fall_q <= going_down;
        rpt_q  <= 1'b0;

        // Release takes priority over everything, including a repeat that
        // happens to be due on the same edge.
        if (going_down) begin
          state_q  <= ST_IDLE;
          held_q   <= 1'b0;
          hold_cnt <= '0;
          rep_cnt  <= '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (going_up) begin
                // Counter reads 1 in the first pressed cycle.
                state_q  <= ST_PRESS;
                hold_cnt <= HW'(1);
              end
            end
            ST_PRESS: begin
              if (hold_cnt == HOLD_LAST) begin
                state_q <= ST_HELD;
                held_q  <= 1'b1;
                rpt_q   <= 1'b1;
                rep_cnt <= RW'(1);
              end else begin
                hold_cnt <= hold_cnt + HW'(1);
              end
            end
            ST_HELD: begin
              if (RPT_ON) begin
                if (rep_cnt == RPT_LAST) begin
                  rpt_q   <= 1'b1;
                  rep_cnt <= RW'(1);
                end else begin
                  rep_cnt <= rep_cnt + RW'(1);
                end
              end
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end

    assign dout[i] = lvl_q;
    assign rise[i] = rise_q;
    assign fall[i] = fall_q;
    assign held[i] = held_q;
    assign rpt[i]  = rpt_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner
//
// Purpose: drives three instances (default, no-repeat, active-low) and checks
// every output against expectations queued when stimulus is applied.
// Ports: none (top-level bench).
module tb_button_conditioner;

  localparam int HOLD = 16;
  localparam int INF  = 1 << 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] din = 2'b00;
  logic [1:0] din_al = 2'b10;

  logic [1:0] dout_m, rise_m, fall_m, held_m, rpt_m;
  logic [1:0] dout_n, rise_n, fall_n, held_n, rpt_n;
  logic [1:0] dout_a, rise_a, fall_a, held_a, rpt_a;

  button_conditioner #(
    .DATA_WIDTH(2), .SYNC_STAGES(2), .NOISE_PERIOD(4), .HOLD_PERIOD(16),
    .REPEAT_PERIOD(8), .ACTIVE_LOW(0)
  ) u_main (
    .clk(clk), .rst(rst), .din(din), .dout(dout_m), .rise(rise_m),
    .fall(fall_m), .held(held_m), .rpt(rpt_m)
  );

  button_conditioner #(
    .DATA_WIDTH(2), .SYNC_STAGES(2), .NOISE_PERIOD(4), .HOLD_PERIOD(16),
    .REPEAT_PERIOD(0), .ACTIVE_LOW(0)
  ) u_norep (
    .clk(clk), .rst(rst), .din(din), .dout(dout_n), .rise(rise_n),
    .fall(fall_n), .held(held_n), .rpt(rpt_n)
  );

  button_conditioner #(
    .DATA_WIDTH(2), .SYNC_STAGES(2), .NOISE_PERIOD(4), .HOLD_PERIOD(16),
    .REPEAT_PERIOD(8), .ACTIVE_LOW(1)
  ) u_al (
    .clk(clk), .rst(rst), .din(din_al), .dout(dout_a), .rise(rise_a),
    .fall(fall_a), .held(held_a), .rpt(rpt_a)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         dut;
    logic [1:0] dout;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] held;
    logic [1:0] rpt;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
  endtask

  // Expected outputs at cycle k for one press whose first dout=1 cycle is t0
  // and whose first dout=0 cycle after release is f.
  function automatic exp_t press_model(int k, int d, int ch, int t0, int f, int rep);
    exp_t e;
    logic hl;
    e.cyc  = k;
    e.dut  = d;
    e.dout = 2'b00;
    e.rise = 2'b00;
    e.fall = 2'b00;
    e.held = 2'b00;
    e.rpt  = 2'b00;
    hl = (k >= t0 + HOLD) && (k < f);
    e.dout[ch] = (k >= t0) && (k < f);
    e.rise[ch] = (k == t0);
    e.fall[ch] = (k == f);
    e.held[ch] = hl;
    e.rpt[ch]  = hl && ((k == t0 + HOLD) || (rep > 0 && ((k - t0 - HOLD) % rep) == 0));
    return e;
  endfunction

  task automatic push_range(input int from, input int to, input int t0, input int f);
    for (int k = from; k <= to; k++) begin
      q.push_back(press_model(k, 0, 0, t0, f, 8));
      q.push_back(press_model(k, 1, 0, t0, f, 0));
    end
  endtask

  task automatic wait_until(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_release(input int hold_cycles);
    int c, t0, f;
    c  = cyc;
    t0 = c + 6;
    f  = t0 + hold_cycles + 6;
    push_range(c, f + 2, t0, f);
    din[0] = 1'b1;
    wait_until(t0 + hold_cycles);
    din[0] = 1'b0;
    wait_until(f + 3);
  endtask

  exp_t       mon_e;
  logic [1:0] g_dout, g_rise, g_fall, g_held, g_rpt;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      if (mon_e.cyc < cyc) begin
        check("stale_expectation", cyc, mon_e.cyc);
      end else begin
        case (mon_e.dut)
          0: begin g_dout = dout_m; g_rise = rise_m; g_fall = fall_m; g_held = held_m; g_rpt = rpt_m; end
          1: begin g_dout = dout_n; g_rise = rise_n; g_fall = fall_n; g_held = held_n; g_rpt = rpt_n; end
          default: begin g_dout = dout_a; g_rise = rise_a; g_fall = fall_a; g_held = held_a; g_rpt = rpt_a; end
        endcase
        check($sformatf("d%0d.dout", mon_e.dut), 32'(g_dout), 32'(mon_e.dout));
        check($sformatf("d%0d.rise", mon_e.dut), 32'(g_rise), 32'(mon_e.rise));
        check($sformatf("d%0d.fall", mon_e.dut), 32'(g_fall), 32'(mon_e.fall));
        check($sformatf("d%0d.held", mon_e.dut), 32'(g_held), 32'(mon_e.held));
        check($sformatf("d%0d.rpt",  mon_e.dut), 32'(g_rpt),  32'(mon_e.rpt));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, t0, t0b, f, x;

    @(posedge clk);
    #1;
    // Reset state
    wait_until(3);
    for (int d = 0; d < 3; d++) q.push_back(press_model(cyc, d, 0, INF, INF, 0));
    rst = 1'b0;

    // Clean press followed by a long hold with repeats, then release
    wait_until(cyc + 2);
    press_release(60);

    // Release lands exactly where a repeat is due: fall wins
    wait_until(cyc + 2);
    press_release(26);

    // Glitches: a 3-cycle pulse, then single-cycle spikes on both channels
    wait_until(cyc + 2);
    c = cyc;
    for (int k = c; k <= c + 30; k++) begin
      q.push_back(press_model(k, 0, 0, INF, INF, 0));
      q.push_back(press_model(k, 1, 0, INF, INF, 0));
    end
    din[0] = 1'b1;
    wait_until(c + 3);
    din[0] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      wait_until(c + 6 + 2 * j);
      din = 2'b11;
      wait_until(c + 7 + 2 * j);
      din = 2'b00;
    end
    wait_until(c + 31);

    // Reset mid-hold with the button still pressed
    wait_until(cyc + 2);
    c   = cyc;
    t0  = c + 6;
    t0b = t0 + 27;
    f   = t0b + 26;
    push_range(c, t0 + 20, t0, INF);
    q.push_back(press_model(t0 + 21, 0, 0, INF, INF, 0));
    q.push_back(press_model(t0 + 21, 1, 0, INF, INF, 0));
    push_range(t0 + 22, f + 2, t0b, f);
    din[0] = 1'b1;
    wait_until(t0 + 20);
    rst = 1'b1;
    wait_until(t0 + 21);
    rst = 1'b0;
    wait_until(t0b + 20);
    din[0] = 1'b0;
    wait_until(f + 3);

    // Active-low instance: channel 0 pressed from reset, channel 1 bouncing
    wait_until(cyc + 2);
    x = cyc;
    q.push_back(press_model(x + 1, 2, 0, INF, INF, 0));
    for (int k = x + 2; k <= x + 55; k++) q.push_back(press_model(k, 2, 0, x + 7, INF, 8));
    rst = 1'b1;
    wait_until(x + 1);
    rst = 1'b0;
    for (int j = 0; j < 16; j++) begin
      wait_until(x + 2 + 3 * j);
      din_al[1] = j[0];
    end
    din_al[1] = 1'b1;
    wait_until(x + 58);

    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
